// File: rtl/prim_esc_ping_ctrl.sv
// Escalation ping initiator: round-robins ping requests over NumEsc escalation senders,
// waits for each response within a programmable window and pulses ping_fail_o on timeout.
module prim_esc_ping_ctrl #(
    parameter int unsigned NumEsc = 4,
    parameter int unsigned CntW   = 16,
    localparam int unsigned IdxW  = (NumEsc > 1) ? $clog2(NumEsc) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic [CntW-1:0]   wait_cyc_i,
    input  logic [CntW-1:0]   timeout_cyc_i,
    input  logic [NumEsc-1:0] esc_en_i,
    input  logic [NumEsc-1:0] ping_ok_i,
    output logic [NumEsc-1:0] ping_en_o,
    output logic              ping_fail_o,
    output logic [IdxW-1:0]   fail_idx_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StPing
    } state_e;

    state_e            state_q;
    logic [IdxW-1:0]   idx_q;
    logic [CntW-1:0]   cnt_q;
    logic              ping_fail_q;
    logic [IdxW-1:0]   fail_idx_q;

    function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
        return (idx == IdxW'(NumEsc - 1)) ? '0 : idx + IdxW'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            cnt_q       <= '0;
            ping_fail_q <= 1'b0;
            fail_idx_q  <= '0;
        end else begin
            ping_fail_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (en_i) begin
                        cnt_q   <= wait_cyc_i;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (!en_i) begin
                        state_q <= StIdle;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CntW'(1);
                    end else if (esc_en_i[idx_q]) begin
                        // An escalating lane must never be pinged; move on without a ping.
                        idx_q <= next_idx(idx_q);
                        cnt_q <= wait_cyc_i;
                    end else begin
                        cnt_q   <= timeout_cyc_i;
                        state_q <= StPing;
                    end
                end
                StPing: begin
                    if (!en_i) begin
                        state_q <= StIdle;
                    end else if (esc_en_i[idx_q] || ping_ok_i[idx_q]) begin
                        idx_q   <= next_idx(idx_q);
                        cnt_q   <= wait_cyc_i;
                        state_q <= StWait;
                    end else if (cnt_q == '0) begin
                        ping_fail_q <= 1'b1;
                        fail_idx_q  <= idx_q;
                        idx_q       <= next_idx(idx_q);
                        cnt_q       <= wait_cyc_i;
                        state_q     <= StWait;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        ping_en_o = '0;
        if (state_q == StPing) begin
            ping_en_o = NumEsc'(1) << idx_q;
        end
    end

    assign busy_o      = (state_q == StPing);
    assign ping_fail_o = ping_fail_q;
    assign fail_idx_o  = fail_idx_q;

`ifndef SYNTHESIS
    ping_en_onehot0_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(ping_en_o));
    idx_in_range_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (32'(idx_q) < NumEsc));
    fail_not_busy_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
        ping_fail_o |-> !busy_o);
`endif

endmodule

// File: tb/tb_prim_esc_ping_ctrl.sv
// Directed bench for prim_esc_ping_ctrl: per-cycle vector table plus a config-latching sequence.
module tb_prim_esc_ping_ctrl;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        en_i = 1'b0;
    logic [15:0] wait_cyc_i = '0;
    logic [15:0] timeout_cyc_i = '0;
    logic [3:0]  esc_en_i = '0;
    logic [3:0]  ping_ok_i = '0;
    logic [3:0]  ping_en_o;
    logic        ping_fail_o;
    logic [1:0]  fail_idx_o;
    logic        busy_o;

    prim_esc_ping_ctrl #(
        .NumEsc(4),
        .CntW  (16)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .en_i         (en_i),
        .wait_cyc_i   (wait_cyc_i),
        .timeout_cyc_i(timeout_cyc_i),
        .esc_en_i     (esc_en_i),
        .ping_ok_i    (ping_ok_i),
        .ping_en_o    (ping_en_o),
        .ping_fail_o  (ping_fail_o),
        .fail_idx_o   (fail_idx_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        en;
        logic [15:0] wait_cyc;
        logic [15:0] timeout_cyc;
        logic [3:0]  esc;
        logic [3:0]  ok;
        logic [3:0]  exp_pe;
        logic        exp_fail;
        logic [1:0]  exp_fidx;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] t_wait;
    logic [15:0] t_to;
    logic [3:0]  t_esc;
    logic [1:0]  t_fidx;
    int          tests = 0;
    int          fails = 0;

    // Each row: inputs held across one rising edge, outputs expected just after that edge.
    task automatic add(input logic rst_n, input logic en, input logic [3:0] ok,
                       input logic [3:0] pe, input logic fail);
        vec_t v;
        v.rst_n       = rst_n;
        v.en          = en;
        v.wait_cyc    = t_wait;
        v.timeout_cyc = t_to;
        v.esc         = t_esc;
        v.ok          = ok;
        v.exp_pe      = pe;
        v.exp_fail    = fail;
        v.exp_fidx    = t_fidx;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int row, input logic [15:0] act,
                         input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (row %0d): got %0h, expected %0h", name, row, act, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int hi;
        logic [3:0] m;

        // Test 1: wait=2, timeout=5, ok two cycles after ping_en, lanes 0,1,2,3,0.
        t_wait = 16'd2; t_to = 16'd5; t_esc = 4'b0000; t_fidx = 2'd0;
        add(0, 0, 4'h0, 4'h0, 0);
        add(0, 0, 4'h0, 4'h0, 0);
        add(1, 1, 4'h0, 4'h0, 0);
        add(1, 1, 4'h0, 4'h0, 0);
        add(1, 1, 4'h0, 4'h0, 0);
        for (int k = 0; k < 5; k++) begin
            m = 4'b0001 << (k % 4);
            add(1, 1, 4'h0, m, 0);
            add(1, 1, 4'h0, m, 0);
            add(1, 1, 4'h0, m, 0);
            add(1, 1, m, 4'h0, 0);
            add(1, 1, 4'h0, 4'h0, 0);
            add(1, 1, 4'h0, 4'h0, 0);
        end

        // Test 2: lane 2 silent, timeout=3; other lanes' ok must be ignored.
        t_wait = 16'd0; t_to = 16'd3;
        add(0, 0, 4'h0, 4'h0, 0);
        add(1, 1, 4'h0, 4'h0, 0);
        add(1, 1, 4'h0, 4'h1, 0);
        add(1, 1, 4'h1, 4'h0, 0);
        add(1, 1, 4'h0, 4'h2, 0);
        add(1, 1, 4'h2, 4'h0, 0);
        add(1, 1, 4'h0, 4'h4, 0);
        add(1, 1, 4'b1011, 4'h4, 0);
        add(1, 1, 4'b1011, 4'h4, 0);
        add(1, 1, 4'b1011, 4'h4, 0);
        t_fidx = 2'd2;
        add(1, 1, 4'b1011, 4'h0, 1);
        add(1, 1, 4'h0, 4'h8, 0);
        add(1, 1, 4'h8, 4'h0, 0);

        // Test 3: lane 1 escalating throughout is skipped.
        t_esc = 4'b0010; t_fidx = 2'd0;
        add(0, 0, 4'h0, 4'h0, 0);
        add(1, 1, 4'h0, 4'h0, 0);
        add(1, 1, 4'h0, 4'h1, 0);
        add(1, 1, 4'h1, 4'h0, 0);
        add(1, 1, 4'h2, 4'h0, 0);
        add(1, 1, 4'h0, 4'h4, 0);
        add(1, 1, 4'h4, 4'h0, 0);
        add(1, 1, 4'h0, 4'h8, 0);
        add(1, 1, 4'h8, 4'h0, 0);
        add(1, 1, 4'h0, 4'h1, 0);
        add(1, 1, 4'h1, 4'h0, 0);

        // Test 4: esc_en_i[0] rises mid-ping -> abort, no fail, lane 1 next.
        t_esc = 4'b0000; t_to = 16'd5;
        add(0, 0, 4'h0, 4'h0, 0);
        add(1, 1, 4'h0, 4'h0, 0);
        add(1, 1, 4'h0, 4'h1, 0);
        t_esc = 4'b0001;
        add(1, 1, 4'h0, 4'h0, 0);
        add(1, 1, 4'h0, 4'h2, 0);
        add(1, 1, 4'h2, 4'h0, 0);
        t_esc = 4'b0000;

        // Test 5: timeout=0: ok on first ping cycle wins; without ok, fail after one cycle.
        t_to = 16'd0;
        add(0, 0, 4'h0, 4'h0, 0);
        add(1, 1, 4'h0, 4'h0, 0);
        add(1, 1, 4'h0, 4'h1, 0);
        add(1, 1, 4'h1, 4'h0, 0);
        add(1, 1, 4'h0, 4'h2, 0);
        t_fidx = 2'd1;
        add(1, 1, 4'h0, 4'h0, 1);
        add(1, 1, 4'h0, 4'h4, 0);
        // en_i dropped mid-ping, then re-enabled: same lane 2 again.
        add(1, 0, 4'h0, 4'h0, 0);
        add(1, 0, 4'h0, 4'h0, 0);
        add(1, 1, 4'h0, 4'h0, 0);
        add(1, 1, 4'h0, 4'h4, 0);
        add(1, 1, 4'h4, 4'h0, 0);

        // Test 6: reset while lane 3 is about to time out -> no pulse, idx back to 0.
        add(1, 1, 4'h0, 4'h8, 0);
        t_fidx = 2'd0;
        add(0, 1, 4'h0, 4'h0, 0);
        add(1, 1, 4'h0, 4'h0, 0);
        add(1, 1, 4'h0, 4'h1, 0);
        add(1, 1, 4'h1, 4'h0, 0);

        foreach (vecs[i]) begin
            rst_ni        = vecs[i].rst_n;
            en_i          = vecs[i].en;
            wait_cyc_i    = vecs[i].wait_cyc;
            timeout_cyc_i = vecs[i].timeout_cyc;
            esc_en_i      = vecs[i].esc;
            ping_ok_i     = vecs[i].ok;
            @(posedge clk);
            #1;
            check("ping_en", i, 16'(ping_en_o), 16'(vecs[i].exp_pe));
            check("ping_fail", i, 16'(ping_fail_o), 16'(vecs[i].exp_fail));
            check("fail_idx", i, 16'(fail_idx_o), 16'(vecs[i].exp_fidx));
            check("busy", i, 16'(busy_o), 16'(vecs[i].exp_pe != 4'h0));
        end

        // Config latching: timeout/wait changes mid-ping only apply at the next load.
        rst_ni = 1'b0; en_i = 1'b0; esc_en_i = '0; ping_ok_i = '0;
        @(posedge clk);
        #1;
        rst_ni = 1'b1; wait_cyc_i = 16'd1; timeout_cyc_i = 16'd2; en_i = 1'b1;
        n = 0;
        while (ping_en_o == 4'h0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latch_ping_start_latency", -1, 16'(n), 16'd3);
        timeout_cyc_i = 16'd100;
        wait_cyc_i = 16'd0;
        hi = 0;
        while (ping_en_o != 4'h0 && hi < 50) begin
            hi++;
            @(posedge clk);
            #1;
        end
        check("latch_ping_high_cycles", -1, 16'(hi), 16'd3);
        check("latch_fail_pulse", -1, 16'(ping_fail_o), 16'd1);
        check("latch_fail_idx", -1, 16'(fail_idx_o), 16'd0);
        @(posedge clk);
        #1;
        check("latch_next_lane", -1, 16'(ping_en_o), 16'h2);
        check("latch_fail_one_cycle", -1, 16'(ping_fail_o), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
